ops_seq: RTL

OPS_SEQ -- requirements
Module: ops_seq

---
 rtl/ops_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ops_seq.sv
// ops_seq: single-request ALU with an iterative restoring divider.
//
// A request (a, b, op) is taken when in_valid and in_ready are both high.
// Most ops finish in one cycle. mod/div with a non-zero divisor run the
// divider for WIDTH cycles. The result is held in DONE until it is consumed.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  request handshake; a, b, op are captured on accept
//   out_valid/ready result handshake; o, carry, err are stable while valid
//   o               result
//   carry           carry out for add, borrow for sub, 0 otherwise
//   err             divide by zero or reserved op
module ops_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             carry,
  output logic             err
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  quo;     // dividend shifts out the top, quotient in the bottom
  logic [WIDTH-1:0]  rem;
  logic [WIDTH-1:0]  dvs;
  logic [CW-1:0]     cnt;
  logic              is_mod;

  // Single-cycle results, computed straight from the request inputs.
  logic [WIDTH:0]    sum, dif;
  logic [WIDTH-1:0]  alu_o;
  logic              alu_c, alu_e, start_div;

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    dif       = {1'b0, a} - {1'b0, b};
    alu_o     = '0;
    alu_c     = 1'b0;
    alu_e     = 1'b0;
    start_div = 1'b0;
    case (op)
      3'b000: begin alu_o = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
      3'b001: begin alu_o = dif[WIDTH-1:0]; alu_c = dif[WIDTH]; end  // borrow == a<b
      3'b010: begin
        if (b == '0) begin alu_o = a; alu_e = 1'b1; end
        else start_div = 1'b1;
      end
      3'b011: begin
        if (b == '0) begin alu_o = '1; alu_e = 1'b1; end
        else start_div = 1'b1;
      end
      3'b100:  alu_o = a & b;
      3'b101:  alu_o = a | b;
      3'b110:  alu_o = a ^ b;
      default: alu_e = 1'b1;  // reserved: o stays 0
    endcase
  end

  // One restoring step: bring the next dividend bit into the partial
  // remainder, try subtracting the divisor, keep the difference if it did
  // not go negative.
  logic [WIDTH:0]    shifted, trial;
  logic              ge;
  logic [WIDTH-1:0]  rem_nx, quo_nx;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
    ge      = ~trial[WIDTH];
    rem_nx  = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nx  = {quo[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      o         <= '0;
      carry     <= 1'b0;
      err       <= 1'b0;
      quo       <= '0;
      rem       <= '0;
      dvs       <= '0;
      cnt       <= '0;
      is_mod    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready is always high here, so in_valid alone means accept
          if (in_valid) begin
            in_ready <= 1'b0;
            if (start_div) begin
              state  <= CALC;
              quo    <= a;
              rem    <= '0;
              dvs    <= b;
              cnt    <= '0;
              is_mod <= ~op[0];
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              o         <= alu_o;
              carry     <= alu_c;
              err       <= alu_e;
            end
          end
        end
        CALC: begin
          quo <= quo_nx;
          rem <= rem_nx;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            o         <= is_mod ? rem_nx : quo_nx;
            carry     <= 1'b0;
            err       <= 1'b0;
          end
        end
        DONE: begin
          // in_ready rises only on the cycle after the consume
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
